// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch / next-PC unit.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } fu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Decoder control outputs for the held instruction.
  typedef struct packed {
    logic jr;
    logic jump;
    logic beq;
    logic bne;
    logic blez;
    logic bgtz;
  } ctrl_t;

  // Sign-extended branch offset in bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_unit_npc_calc.sv
// Combinational next-PC selection: jr > jump > taken branch > sequential.
module fetch_unit_npc_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_idx,
  input  ctrl_t       ctrl,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] npc,
  output logic        misaligned
);

  logic [31:0] pc_plus4;
  logic        taken;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    taken = 1'b0;
    if (ctrl.beq  && (rs_data == rt_data))  taken = 1'b1;
    if (ctrl.bne  && (rs_data != rt_data))  taken = 1'b1;
    if (ctrl.blez && ($signed(rs_data) <= 0)) taken = 1'b1;
    if (ctrl.bgtz && ($signed(rs_data) > 0))  taken = 1'b1;
  end

  always_comb begin
    npc = pc_plus4;
    if (ctrl.jr) begin
      npc = rs_data;
    end else if (ctrl.jump) begin
      npc = {pc_plus4[31:28], instr_idx, 2'b00};
    end else if (taken) begin
      npc = pc_plus4 + branch_offset(instr_idx[15:0]);
    end
  end

  // Only a jr target can carry nonzero low bits.
  assign misaligned = |npc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time and holds it
// for the decoder until it retires, then redirects via the npc calculator.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  fetch_unit_if.master imem,
  output logic        instr_valid,
  output logic [31:0] instr_o,
  output logic [5:0]  op_o,
  output logic [5:0]  funct_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  input  logic        dec_ready,
  input  logic        jump,
  input  logic        jr,
  input  logic        beq,
  input  logic        bne,
  input  logic        blez,
  input  logic        bgtz,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        fetch_err
);

  fu_state_e   state, state_next;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] npc;
  logic        misaligned;
  logic        capture;
  logic        retire;
  logic        trap;
  ctrl_t       ctrl;

  assign ctrl = '{jr: jr, jump: jump, beq: beq, bne: bne, blez: blez, bgtz: bgtz};

  fetch_unit_npc_calc u_npc_calc (
    .pc         (pc),
    .instr_idx  (instr[25:0]),
    .ctrl       (ctrl),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .npc        (npc),
    .misaligned (misaligned)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    retire     = 1'b0;
    trap       = 1'b0;
    unique case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        if (imem.ack) begin
          capture    = 1'b1;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (dec_ready) begin
          if (CHECK_ALIGN && misaligned) begin
            trap       = 1'b1;
            state_next = S_ERR;
          end else begin
            retire     = 1'b1;
            state_next = S_REQ;
          end
        end
      end
      S_ERR: state_next = S_ERR;
      default: state_next = S_IDLE;
    endcase
  end

  // The instruction register is cleared on retire so the decoder sees a NOP while nothing is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      instr     <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (capture) instr <= imem.rdata;
      if (retire) begin
        pc    <= {npc[31:2], 2'b00};
        instr <= '0;
      end
      if (trap) begin
        instr     <= '0;
        fetch_err <= 1'b1;
      end
    end
  end

  assign imem.req    = (state == S_REQ);
  assign imem.addr   = pc;
  assign instr_valid = (state == S_HOLD);
  assign instr_o     = instr;
  assign op_o        = instr[31:26];
  assign funct_o     = instr[5:0];
  assign pc_o        = pc;
  assign pc_plus4_o  = pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table of instructions plus an
// address scoreboard, followed by reset-mid-fetch and misaligned-jr sequences.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_JR   = 6'b100000;
  localparam logic [5:0] C_JUMP = 6'b010000;
  localparam logic [5:0] C_BEQ  = 6'b001000;
  localparam logic [5:0] C_BNE  = 6'b000100;
  localparam logic [5:0] C_BLEZ = 6'b000010;
  localparam logic [5:0] C_BGTZ = 6'b000001;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  ctrl;
    logic [31:0] rs;
    logic [31:0] rt;
    int          delay;
    int          stall;
    logic [31:0] npc;
    bit          err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr_o;
  logic [5:0]  op_o;
  logic [5:0]  funct_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        dec_ready;
  logic        jump, jr, beq, bne, blez, bgtz;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        fetch_err;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  vec_t        tbl[17];

  fetch_unit_if imem();

  fetch_unit #(.RESET_PC(32'h0000_3000), .CHECK_ALIGN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem),
    .instr_valid (instr_valid),
    .instr_o     (instr_o),
    .op_o        (op_o),
    .funct_o     (funct_o),
    .pc_o        (pc_o),
    .pc_plus4_o  (pc_plus4_o),
    .dec_ready   (dec_ready),
    .jump        (jump),
    .jr          (jr),
    .beq         (beq),
    .bne         (bne),
    .blez        (blez),
    .bgtz        (bgtz),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic set_ctrl(input logic [5:0] c);
    {jr, jump, beq, bne, blez, bgtz} = c;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (imem.req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (imem.req !== 1'b1) begin
      check({tag, "_req_timeout"}, 32'(imem.req), 32'd1);
      finish_tb();
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] a;
    wait_req(tag);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      a = 32'hxxxx_xxxx;
    end else begin
      a = exp_q.pop_front();
    end
    check({tag, "_addr"}, imem.addr, a);
    check({tag, "_pc"}, pc_o, a);
    check({tag, "_op_idle"}, 32'({instr_valid, op_o}), 32'd0);
    for (int d = 0; d < v.delay; d++) begin
      @(negedge clk);
      check({tag, "_req_wait"}, 32'(imem.req), 32'd1);
      check({tag, "_addr_wait"}, imem.addr, a);
    end
    imem.ack   = 1'b1;
    imem.rdata = v.instr;
    @(negedge clk);
    imem.ack   = 1'b0;
    imem.rdata = $urandom;
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_req_hold"}, 32'(imem.req), 32'd0);
    check({tag, "_instr"}, instr_o, v.instr);
    check({tag, "_op_funct"}, 32'({op_o, funct_o}), 32'({v.instr[31:26], v.instr[5:0]}));
    check({tag, "_pc_plus4"}, pc_plus4_o, a + 32'd4);
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      check({tag, "_stall_instr"}, instr_o, v.instr);
      check({tag, "_stall_pc"}, pc_o, a);
    end
    set_ctrl(v.ctrl);
    rs_data   = v.rs;
    rt_data   = v.rt;
    dec_ready = 1'b1;
    if (!v.err) exp_q.push_back(v.npc);
    @(negedge clk);
    dec_ready = 1'b0;
    set_ctrl(C_NONE);
    if (v.err) begin
      check({tag, "_err"}, 32'(fetch_err), 32'd1);
      check({tag, "_err_req"}, 32'(imem.req), 32'd0);
      check({tag, "_err_pc"}, pc_o, a);
    end
    check({tag, "_cleared"}, 32'({instr_valid, op_o, funct_o}), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    rst        = 1'b1;
    imem.ack   = 1'b0;
    imem.rdata = '0;
    dec_ready  = 1'b0;
    set_ctrl(C_NONE);
    rs_data    = '0;
    rt_data    = '0;

    //                instr          ctrl            rs            rt      dly stl npc           err
    tbl[0]  = '{32'h2008_0005, C_NONE,        32'd0,        32'd0,        0, 0, 32'h0000_3004, 0};
    tbl[1]  = '{32'h0800_0C04, C_JUMP,        32'd0,        32'd0,        3, 5, 32'h0000_3010, 0};
    tbl[2]  = '{32'h1000_FFFC, C_BEQ,         32'd7,        32'd7,        1, 0, 32'h0000_3004, 0};
    tbl[3]  = '{32'h1400_0010, C_BNE,         32'd5,        32'd5,        0, 2, 32'h0000_3008, 0};
    tbl[4]  = '{32'h1800_0001, C_BLEZ,        32'd0,        32'd0,        2, 0, 32'h0000_3010, 0};
    tbl[5]  = '{32'h1000_FFFC, C_BEQ,         32'd7,        32'd8,        0, 0, 32'h0000_3014, 0};
    tbl[6]  = '{32'h1C00_0010, C_BGTZ,        32'h8000_0000, 32'd0,       0, 1, 32'h0000_3018, 0};
    tbl[7]  = '{32'h1C00_FFFA, C_BGTZ,        32'd1,        32'd0,        1, 0, 32'h0000_3004, 0};
    tbl[8]  = '{32'h0800_0C04, C_JR | C_JUMP, 32'h0000_3000, 32'd0,       0, 0, 32'h0000_3000, 0};
    tbl[9]  = '{32'h0C00_0C10, C_JUMP,        32'd0,        32'd0,        0, 1, 32'h0000_3040, 0};
    tbl[10] = '{32'h0800_0C00, C_JUMP | C_BEQ, 32'd1,       32'd1,        0, 0, 32'h0000_3000, 0};
    tbl[11] = '{32'h1800_0003, C_BLEZ,        32'hFFFF_FFFF, 32'd0,       2, 0, 32'h0000_3010, 0};
    tbl[12] = '{32'h0000_0008, C_JR,          32'hFFFF_FFFC, 32'd0,       0, 0, 32'hFFFF_FFFC, 0};
    tbl[13] = '{32'h0000_0000, C_NONE,        32'd0,        32'd0,        1, 0, 32'h0000_0000, 0};
    tbl[14] = '{32'h1400_8000, C_BNE,         32'd1,        32'd2,        0, 0, 32'hFFFE_0004, 0};
    tbl[15] = '{32'h0800_0C00, C_JUMP,        32'd0,        32'd0,        0, 0, 32'hF000_3000, 0};
    tbl[16] = '{32'h0000_0008, C_JR | C_BGTZ, 32'h0000_3020, 32'd0,       0, 0, 32'h0000_3020, 0};

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_req", 32'(imem.req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    check("rst_pc", pc_o, 32'h0000_3000);
    check("rst_instr", instr_o, 32'd0);
    exp_q.push_back(32'h0000_3000);

    for (int i = 0; i < 17; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // Reset in the middle of a fetch wait; an ack during S_IDLE is ignored.
    wait_req("mid");
    a = exp_q.pop_front();
    check("mid_addr", imem.addr, a);
    @(negedge clk);
    check("mid_req_wait", 32'(imem.req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_req", 32'(imem.req), 32'd0);
    check("mid_rst_pc", pc_o, 32'h0000_3000);
    imem.ack   = 1'b1;
    imem.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem.ack = 1'b0;
    check("mid_idle_ack_req", 32'(imem.req), 32'd1);
    check("mid_idle_ack_valid", 32'(instr_valid), 32'd0);
    check("mid_idle_ack_instr", instr_o, 32'd0);
    @(negedge clk);
    check("mid_still_req", 32'(imem.req), 32'd1);
    check("mid_still_invalid", 32'(instr_valid), 32'd0);
    exp_q.push_back(32'h0000_3000);

    // Misaligned jr target traps until reset.
    run_vec('{32'h03E0_0008, C_JR, 32'h0000_3002, 32'd0, 0, 0, 32'd0, 1}, "err");
    for (int k = 0; k < 4; k++) begin
      imem.ack   = 1'b1;
      imem.rdata = $urandom;
      dec_ready  = 1'b1;
      @(negedge clk);
      check("err_sticky", 32'(fetch_err), 32'd1);
      check("err_no_req", 32'(imem.req), 32'd0);
      check("err_no_valid", 32'(instr_valid), 32'd0);
    end
    imem.ack  = 1'b0;
    dec_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("err_rst_clear", 32'(fetch_err), 32'd0);
    check("err_rst_pc", pc_o, 32'h0000_3000);
    exp_q.push_back(32'h0000_3000);
    run_vec(tbl[0], "post");
    wait_req("final");
    a = exp_q.pop_front();
    check("final_addr", imem.addr, a);

    finish_tb();
  end

  initial begin
    #200000;
    check("global_timeout", 32'd0, 32'd1);
    finish_tb();
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch and next-PC unit that sits in front of the instruction decoder.
- Owns the PC and fetches words from instruction memory over a req/ack handshake.
- Presents the held instruction, with op/funct fields, to the decoder.
- Computes the next PC from the decoder's jump/jr/beq/bne/blez/bgtz outputs and the operands supplied by the datapath.
- No branch delay slot; one instruction in flight.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
CHECK_ALIGN, 1, 1 = a redirect target with [1:0]!=0 enters the error state; 0 = low bits are forced to 00

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; synchronous, active-high
imem_req  out  1  fetch request, held until ack
imem_addr  out  32  fetch address (= pc_o), stable while imem_req=1
imem_ack  in  1  read data valid this cycle
imem_rdata  in  32  instruction word
instr_valid  out  1  instr_o/op_o/funct_o hold a fetched instruction
instr_o  out  32  held instruction
op_o  out  6  instr_o[31:26], drives decoder op_i
funct_o  out  6  instr_o[5:0], drives decoder funct_i
pc_o  out  32  PC of the held or requested instruction
pc_plus4_o  out  32  pc_o+4, link value for JAL
dec_ready  in  1  datapath retires the held instruction this cycle
jump, jr, beq, bne, blez, bgtz  in  1 each  decoder control outputs for instr_o
rs_data  in  32  GPR[rs] of the held instruction
rt_data  in  32  GPR[rt] of the held instruction
fetch_err  out  1  sticky misaligned-target flag

Behaviour:
- FSM states: S_IDLE, S_REQ, S_HOLD, S_ERR.
- Reset (rst=1 at an edge), from any state including mid-fetch:
  - state=S_IDLE, pc=RESET_PC, instr=0.
  - instr_valid=0, imem_req=0, fetch_err=0.
  - An in-flight fetch is abandoned.
- S_IDLE:
  - imem_req=0; imem_ack is ignored.
  - Next cycle goes to S_REQ.
  - This one idle cycle after reset absorbs any stale ack.
- S_REQ:
  - imem_req=1, imem_addr=pc.
  - If imem_ack=1 in the same cycle: instr<=imem_rdata, go to S_HOLD.
  - Otherwise stay in S_REQ with addr unchanged.
  - Minimum latency: request-to-instr_valid is 1 cycle (ack in the first S_REQ cycle).
- S_HOLD:
  - instr_valid=1, imem_req=0; instr and pc are frozen.
  - dec_ready=0 stalls here indefinitely.
  - If dec_ready=1: pc<=npc, go to S_REQ.
  - A misaligned npc with CHECK_ALIGN=1 instead goes to S_ERR: pc is unchanged and fetch_err<=1.
- S_ERR:
  - imem_req=0, instr_valid=0, fetch_err=1.
  - Exits only on rst.
- npc priority, all arithmetic modulo 2^32:
  1. jr: npc=rs_data.
  2. jump: npc={pc_plus4[31:28], instr[25:0], 2'b00}.
  3. Taken branch: npc=pc_plus4 + (sext(instr[15:0])<<2).
     - beq taken when rs_data==rt_data.
     - bne taken when rs_data!=rt_data.
     - blez taken when $signed(rs_data)<=0.
     - bgtz taken when $signed(rs_data)>0.
  4. Otherwise npc=pc_plus4.
- Simultaneous control bits (illegal from the decoder) resolve by the priority above.
- pc_plus4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000.
- Branch offset arithmetic wraps silently; only the alignment of jr targets can fail. Sequential, jump and branch targets are always aligned by construction.
- Outputs change only at clock edges. The exception is npc: it is combinational in S_HOLD and is not exported.
- op_o/funct_o are 0 whenever instr_valid=0 (instr register reset/cleared). The decoder therefore sees op=0,funct=0, i.e. SLL $0 as a NOP, and the datapath gates writes with instr_valid.

Decomposition:
- Add to the shared mips_para.v:
  - State encodings `FU_IDLE/`FU_REQ/`FU_HOLD/`FU_ERR (2 bits).
  - `RESET_PC_DEFAULT.
- Opcode/funct constants already live there and are not redefined.
- One combinational sub-module, npc_calc:
  - Inputs: pc, instr, jump/jr/beq/bne/blez/bgtz, rs_data, rt_data.
  - Outputs: npc, misaligned.
  - fetch_unit keeps the FSM and registers.

Test Plan:
- Reset, then ack on the first S_REQ cycle with rdata=32'h2008_0005 (addi) and dec_ready=1, all control bits 0 -> imem_addr=32'h3000; the next request has imem_addr=32'h3004; op_o=6'h08 while valid.
- Ack delayed 3 cycles -> imem_req stays high with addr stable for 4 cycles; instr_valid rises the cycle after ack; with dec_ready=0 for 5 cycles the instruction and pc stay frozen.
- beq at 32'h3010, imm=16'hFFFC, rs=rt=7 -> next addr 32'h3004; same with rt=8 -> 32'h3014; bgtz with rs=32'h8000_0000 -> not taken (32'h3014).
- jal at 32'h3000, instr[25:0]=26'h0000C10 -> next addr 32'h0000_3040, pc_plus4_o=32'h3004 while held; jr with rs_data=32'h3002 -> S_ERR, fetch_err=1, imem_req=0 until rst.
- rst asserted in the middle of a 3-cycle wait -> imem_req=0 for 2 cycles (reset edge plus S_IDLE) and an ack arriving in S_IDLE is ignored; the next request has addr=RESET_PC.
- pc=32'hFFFF_FFFC with a sequential instruction retired -> next addr 32'h0000_0000.
